// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared core definitions for the issue scoreboard slice.
//   - REG_ADDR_W : architectural register address width
//   - ALU_OP_W   : ALU op code width carried from decode to execute
//   - sb_state_e : scoreboard control state (run / stalled / flushing)
// -----------------------------------------------------------------------------
package core_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int ALU_OP_W   = 4;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_STALL = 2'd1,
    SB_FLUSH = 2'd2
  } sb_state_e;

endpackage

// File: rtl/issue_scoreboard_if.sv
// -----------------------------------------------------------------------------
// issue_scoreboard_if
//   Bundles the three buses around the scoreboard:
//   - decode  : dec_valid/dec_ready plus operand/destination/op fields
//   - issue   : iss_valid/iss_ready plus issued rd/write-enable/op
//   - control : writeback retire (wb_valid/wb_rd) and pipeline flush
//   Modports:
//   - slave  : the scoreboard's view
//   - master : the surrounding pipeline's (decoder, execute, writeback) view
// -----------------------------------------------------------------------------
interface issue_scoreboard_if;
  import core_pkg::*;

  // Decode side
  logic                  dec_valid;
  logic                  dec_ready;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  dec_use_rs1;
  logic                  dec_use_rs2;
  logic                  dec_reg_write;
  logic [ALU_OP_W-1:0]   dec_alu_op;

  // Issue side
  logic                  iss_valid;
  logic                  iss_ready;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic                  iss_reg_write;
  logic [ALU_OP_W-1:0]   iss_alu_op;

  // Writeback and redirect
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  flush;

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rd,
    input  dec_use_rs1, dec_use_rs2, dec_reg_write, dec_alu_op,
    output dec_ready,
    output iss_valid, iss_rd, iss_reg_write, iss_alu_op,
    input  iss_ready,
    input  wb_valid, wb_rd, flush
  );

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rd,
    output dec_use_rs1, dec_use_rs2, dec_reg_write, dec_alu_op,
    input  dec_ready,
    input  iss_valid, iss_rd, iss_reg_write, iss_alu_op,
    output iss_ready,
    output wb_valid, wb_rd, flush
  );

endinterface

// File: rtl/sb_busy_table.sv
// -----------------------------------------------------------------------------
// sb_busy_table
//   One busy bit per architectural register. A bit is set when a writing
//   instruction issues and cleared when its writeback retires.
//   Ports:
//   - clk, reset         : clock, synchronous active-high reset
//   - i_set_en/addr      : mark a register busy
//   - i_clr_en/addr      : mark a register free
//   - i_clr_all          : free every register (flush)
//   - i_rs1/rs2/rd_addr  : three read addresses
//   - o_rs1/rs2/rd_busy  : corresponding busy bits
//   - o_busy_mask        : all busy bits, bit 0 (x0) always 0
// -----------------------------------------------------------------------------
module sb_busy_table
  import core_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic                  i_clr_all,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [REG_ADDR_W-1:0] i_rd_addr,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic                  o_rd_busy,
  output logic [NUM_REGS-1:0]   o_busy_mask
);

  logic [NUM_REGS-1:0] r_busy;

  // NOTE: the busy bits are reset even though they look like a small memory:
  // a stale 1 after reset would stall forever on a register nobody will write.
  always_ff @(posedge clk) begin
    if (reset || i_clr_all) begin
      r_busy <= '0;
    end else begin
      // Set and clear never target the same register in one cycle because a
      // WAW hazard blocks the accept, so their order here is immaterial.
      if (i_clr_en) r_busy[i_clr_addr] <= 1'b0;
      if (i_set_en) r_busy[i_set_addr] <= 1'b1;
      // x0 is hardwired zero and can never be busy.
      r_busy[0] <= 1'b0;
    end
  end

  assign o_rs1_busy  = r_busy[i_rs1_addr];
  assign o_rs2_busy  = r_busy[i_rs2_addr];
  assign o_rd_busy   = r_busy[i_rd_addr];
  assign o_busy_mask = r_busy;

endmodule

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//   In-order single-issue scheduler between decode and execute. Stalls any
//   decoded instruction with a RAW/WAW hazard on a busy register, bounds the
//   number of outstanding register writes, presents accepted instructions on
//   a registered valid/ready issue stage and drops all state on flush.
//   Ports:
//   - clk, reset : clock, synchronous active-high reset
//   - bus        : decode / issue / writeback / flush buses (slave modport)
//   - busy_mask  : registered busy bit per register (bit 0 always 0)
//   - inflight   : issued but not yet written-back register writes
//   - stall_cnt  : saturating count of cycles with dec_valid & !dec_ready
//   - err_wb     : sticky, writeback to a non-busy register or to x0
// -----------------------------------------------------------------------------
module issue_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                reset,
  issue_scoreboard_if.slave   bus,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    inflight,
  output logic [31:0]         stall_cnt,
  output logic                err_wb
);

  // Control state and registered outputs
  sb_state_e             r_state;
  logic                  r_iss_valid;
  logic [REG_ADDR_W-1:0] r_iss_rd;
  logic                  r_iss_reg_write;
  logic [ALU_OP_W-1:0]   r_iss_alu_op;
  logic [CNT_W-1:0]      r_inflight;
  logic [31:0]           r_stall_cnt;
  logic                  r_err_wb;

  // Decode-time decisions
  logic                  w_eff_we;
  logic                  w_rs1_busy;
  logic                  w_rs2_busy;
  logic                  w_rd_busy;
  logic                  w_hazard;
  logic                  w_full;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_stall;
  logic                  w_set_en;
  logic                  w_wb_hit;
  logic                  w_clr_en;
  logic                  w_wb_bad;
  logic [NUM_REGS-1:0]   w_busy_mask;
  logic [CNT_W-1:0]      w_inflight_nxt;

  sb_busy_table #(
    .NUM_REGS (NUM_REGS)
  ) u_busy_table (
    .clk         (clk),
    .reset       (reset),
    .i_set_en    (w_set_en),
    .i_set_addr  (bus.dec_rd),
    .i_clr_en    (w_clr_en),
    .i_clr_addr  (bus.wb_rd),
    .i_clr_all   (bus.flush),
    .i_rs1_addr  (bus.dec_rs1),
    .i_rs2_addr  (bus.dec_rs2),
    .i_rd_addr   (bus.dec_rd),
    .o_rs1_busy  (w_rs1_busy),
    .o_rs2_busy  (w_rs2_busy),
    .o_rd_busy   (w_rd_busy),
    .o_busy_mask (w_busy_mask)
  );

  // Writes to x0 are architectural no-ops: they neither reserve a register
  // nor consume an in-flight slot.
  assign w_eff_we = bus.dec_reg_write && (bus.dec_rd != '0);

  // Hazards look only at registered busy bits; a writeback in this same cycle
  // does not unblock a dependent instruction until the next cycle.
  assign w_hazard = (bus.dec_use_rs1 && w_rs1_busy) ||
                    (bus.dec_use_rs2 && w_rs2_busy) ||
                    (w_eff_we        && w_rd_busy);

  assign w_full   = w_eff_we && (r_inflight == CNT_W'(MAX_INFLIGHT));

  assign w_ready  = (r_state != SB_FLUSH) && !bus.flush && !w_hazard && !w_full &&
                    (!r_iss_valid || bus.iss_ready);

  assign w_accept = bus.dec_valid && w_ready;
  assign w_stall  = bus.dec_valid && !w_ready;
  assign w_set_en = w_accept && w_eff_we;

  // A writeback only retires a register that is actually outstanding; x0 and
  // free registers are flagged as errors instead. Flush discards writebacks.
  assign w_wb_hit = bus.wb_valid && (bus.wb_rd != '0) && w_busy_mask[bus.wb_rd];
  assign w_clr_en = w_wb_hit && !bus.flush;
  assign w_wb_bad = bus.wb_valid && !w_wb_hit && !bus.flush;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_inflight_nxt = r_inflight;
    case ({w_set_en, w_clr_en})
      2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1);
      2'b01:   w_inflight_nxt = r_inflight - CNT_W'(1);
      default: w_inflight_nxt = r_inflight;
    endcase
  end

  // Control FSM. Flush wins over everything except reset; FLUSH lasts one
  // cycle so that decode sees dec_ready low for the flush cycle and the next.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SB_RUN;
    end else if (bus.flush) begin
      r_state <= SB_FLUSH;
    end else begin
      case (r_state)
        SB_RUN:   if (w_stall) r_state <= SB_STALL;
        SB_STALL: if (w_ready) r_state <= SB_RUN;
        SB_FLUSH: r_state <= SB_RUN;
        default:  r_state <= SB_RUN;
      endcase
    end
  end

  // Issue register: loads on accept, holds while execute back-pressures and
  // drops valid once execute takes it with nothing new behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_iss_valid     <= 1'b0;
      r_iss_rd        <= '0;
      r_iss_reg_write <= 1'b0;
      r_iss_alu_op    <= '0;
    end else if (bus.flush) begin
      r_iss_valid     <= 1'b0;
    end else if (w_accept) begin
      r_iss_valid     <= 1'b1;
      r_iss_rd        <= bus.dec_rd;
      r_iss_reg_write <= w_eff_we;
      r_iss_alu_op    <= bus.dec_alu_op;
    end else if (bus.iss_ready) begin
      r_iss_valid     <= 1'b0;
    end
  end

  // Counters and status. stall_cnt and err_wb survive a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight  <= '0;
      r_stall_cnt <= '0;
      r_err_wb    <= 1'b0;
    end else begin
      r_inflight <= bus.flush ? '0 : w_inflight_nxt;
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_wb_bad) r_err_wb <= 1'b1;
    end
  end

  assign bus.dec_ready     = w_ready;
  assign bus.iss_valid     = r_iss_valid;
  assign bus.iss_rd        = r_iss_rd;
  assign bus.iss_reg_write = r_iss_reg_write;
  assign bus.iss_alu_op    = r_iss_alu_op;

  assign busy_mask = w_busy_mask;
  assign inflight  = r_inflight;
  assign stall_cnt = r_stall_cnt;
  assign err_wb    = r_err_wb;

endmodule
